// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Optional stall statistics are enabled with ARB_STATS_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arbState_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    function automatic int latCntW(input int lat);
        int m;
        m = (lat > 1) ? lat : 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports.
// Keeps the data-grant streak so fetch is never starved.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 3
) (
    input  logic clock,
    input  logic rst,
    input  logic ifReq,
    input  logic dmReq,
    input  logic grantEvt,
    output logic grantDm
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0] dstreak;

    // Data wins unless fetch has already waited out a full streak.
    assign grantDm = dmReq && !(ifReq && (dstreak == STREAK_MAX));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            dstreak <= '0;
        end else if (grantEvt) begin
            if (grantDm && ifReq) begin
                if (dstreak != STREAK_MAX) begin
                    dstreak <= dstreak + 1'b1;
                end
            end else begin
                dstreak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by instruction fetch and LDM/STM.
// ARB_STATS_EN adds a saturating stall_cnt output.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 19,
    parameter int DATA_W      = 8,
    parameter int MEM_LAT     = 2,
    parameter int MAX_DSTREAK = 3
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_ack,
    output logic [INSTR_W-1:0] if_rdata,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [ADDR_W-1:0]  dm_addr,
    input  logic [DATA_W-1:0]  dm_wdata,
    output logic               dm_ack,
    output logic [DATA_W-1:0]  dm_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               mem_read,
    output logic               mem_write,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int CNT_W = latCntW(MEM_LAT);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    arbState_t        state;
    owner_t           owner;
    logic             isWrite;
    logic [CNT_W-1:0] latCnt;
    logic             grantDm;
    logic             grantEvt;

    assign grantEvt = (state == IDLE) && (if_req || dm_req);
    assign busy     = (state != IDLE);

    mem_arb_prio #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) uPrio (
        .clock   (clock),
        .rst     (rst),
        .ifReq   (if_req),
        .dmReq   (dm_req),
        .grantEvt(grantEvt),
        .grantDm (grantDm)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            isWrite   <= 1'b0;
            latCnt    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grantEvt) begin
                        state <= ACCESS;
                        if (grantDm) begin
                            owner     <= OWN_DM;
                            isWrite   <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= INSTR_W'(dm_wdata);
                            mem_read  <= !dm_we;
                            mem_write <= dm_we;
                            latCnt    <= dm_we ? '0 : LAT_INIT;
                        end else begin
                            owner    <= OWN_IF;
                            isWrite  <= 1'b0;
                            mem_addr <= if_addr;
                            mem_read <= 1'b1;
                            latCnt   <= LAT_INIT;
                        end
                    end
                end
                ACCESS: begin
                    // latCnt reaching zero marks the cycle mem_rdata is valid.
                    if (latCnt == '0) begin
                        state <= RESP;
                        if (owner == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!isWrite) begin
                                dm_rdata <= mem_rdata[DATA_W-1:0];
                            end
                        end
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic ifStall;
    logic dmStall;

    assign ifStall = if_req && !(busy && (owner == OWN_IF));
    assign dmStall = dm_req && !(busy && (owner == OWN_DM));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((ifStall || dmStall) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and data access (LDM/STM) of the processor datapath.
- Sits between the fetch unit / LDM-STM path and the memory macro.
- Serialises requests, drives fixed-latency memory strobes, returns acknowledged read data.
- Data port has priority; a streak limit prevents fetch starvation.

Parameters:
- ADDR_W, 12, memory address width.
- INSTR_W, 19, memory word and instruction width.
- DATA_W, 8, data-port width (low bits of memory word).
- MEM_LAT, 2, cycles from read strobe to valid mem_rdata; legal range >=1.
- MAX_DSTREAK, 3, consecutive data grants allowed while fetch waits; legal range >=1.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  INSTR_W  fetched instruction, held until next if_ack.
- dm_req  in  1  data request, level, held until dm_ack.
- dm_we  in  1  1 = store (STM), 0 = load (LDM).
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle pulse; load data valid, or store done.
- dm_rdata  out  DATA_W  load data, held until next dm_ack of a load.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  INSTR_W  dm_wdata zero-extended.
- mem_read  out  1  one-cycle read strobe.
- mem_write  out  1  one-cycle write strobe.
- mem_rdata  in  INSTR_W  valid exactly MEM_LAT cycles after mem_read.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset: state IDLE, dstreak=0. Every output is 0 (if_rdata, dm_rdata, mem_addr, mem_wdata included).
- FSM states: IDLE, ACCESS, RESP. One transaction outstanding.
- IDLE, no request: remain in IDLE.
- IDLE, any request at clock edge t: latch owner, address, write flag and wdata; go to ACCESS.
- ACCESS, first cycle (t+1):
  - mem_read or mem_write high for exactly this cycle.
  - mem_addr/mem_wdata stay stable through RESP.
- Read: mem_rdata is sampled at the end of cycle t+1+MEM_LAT into the owner's rdata register; RESP in t+2+MEM_LAT.
- Write: RESP in t+2; no data capture.
- RESP: owner's ack=1 for one cycle; next state IDLE.
- Latency from the IDLE sampling cycle: read ack at t+2+MEM_LAT, store ack at t+2.
- Back-to-back: the requester deasserts req, or presents a new request, at the edge ending the ack cycle; a new request can be sampled in the following IDLE cycle.
- Arbitration when both requests are high in IDLE:
  - Grant data, unless dstreak==MAX_DSTREAK; then grant fetch.
- dstreak update:
  - Data granted while if_req high: dstreak++ (saturates at MAX_DSTREAK).
  - Fetch granted, or data granted with if_req low: dstreak=0.
- Fetch with dm_we: dm_we is ignored for fetch; fetch is always a read.
- Data load: dm_rdata = mem_rdata[DATA_W-1:0].
- req dropped mid-transaction: the transaction still completes and ack is still issued.
- Reset mid-operation: return to IDLE immediately and suppress any pending ack. A write already strobed is not undone.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds output stall_cnt [15:0]:
  - +1 per cycle in which if_req or dm_req is high and that port is not the current owner in ACCESS/RESP.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: port absent, no counter logic.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP).
  - owner encoding (OWN_IF=0, OWN_DM=1).
  - latency-counter width function, clog2(MAX(MEM_LAT,1)+1).
- One natural sub-module: mem_arb_prio.
  - Combinational grant decision plus the registered dstreak counter.
  - Inputs: if_req, dm_req, grant-event strobe.
- FSM and datapath registers stay in the top level.

Test Plan:
- Single fetch, MEM_LAT=2, if_addr=12'h010, mem_rdata=19'h1A5A5 at read+2 -> mem_read pulse cycle t+1 with mem_addr=12'h010; if_ack at t+4; if_rdata=19'h1A5A5.
- Store, dm_addr=12'h080, dm_wdata=8'h3C -> mem_write one cycle at t+1, mem_wdata=19'h0003C; dm_ack at t+2; no mem_read.
- Load, memory returns 19'h7FFE9 -> dm_rdata=8'hE9; if_ack stays 0.
- Both requesting continuously, MAX_DSTREAK=3 -> grant order DM, DM, DM, IF, DM, DM, DM, IF; dstreak resets after each IF grant.
- rst asserted in the second ACCESS cycle of a read -> all outputs 0 asynchronously, no ack; after release a new if_req completes normally.
- ARB_STATS_EN: fetch waits through three data transactions at MEM_LAT=1 -> stall_cnt equals the cycles if_req spent not being served, checked against the model; value held when no request.
